conv_frame_sequencer: RTL

// - Drives the forward_pass_top pixel-stream input from a 64-bit image word memory.
// - Fetches each image in order and replays it PASSES times. Each replay is one frame.
// - Generates the ena/frame/line/dim framing strobes and inserts an idle gap between images.
// - Counts forward-pass results from the valid output. Sits between the image buffer and forward_pass_top.

---
 rtl/conv_frame_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_sequencer.sv
// Replays each image PASSES times as framed pixel streams from a 64-bit word memory and counts results.
// Optional CFS_WAIT_VALID_EN: the inter-image gap also waits for a result pulse of the current image.
module conv_frame_sequencer #(
  parameter int unsigned WORD_W        = 64,
  parameter int unsigned WORDS_PER_ROW = 4,
  parameter int unsigned ROWS          = 35,
  parameter int unsigned PASSES        = 5,
  parameter int unsigned GAP_CYCLES    = 200,
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned IMG_CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IMG_CNT_W-1:0] num_img,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic [7:0]           ima,
  output logic                 ena_in,
  output logic                 frame_start_in,
  output logic                 frame_start_dim_in,
  output logic                 line_start_in,
  output logic                 frame_end_in,
  output logic                 frame_end_dim_in,
  input  logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [IMG_CNT_W-1:0] result_cnt
);
  localparam int unsigned BYTES     = WORD_W / 8;
  localparam int unsigned BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned WW        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int unsigned GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned IMG_WORDS = ROWS * WORDS_PER_ROW;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STREAM, S_GAP, S_FIN} state_t;

  state_t                 state;
  logic [BW-1:0]          b_cnt;
  logic [WW-1:0]          w_cnt;
  logic [RW-1:0]          row_cnt;
  logic [PW-1:0]          pass;
  logic [GW-1:0]          gap_cnt;
  logic [IMG_CNT_W-1:0]   img_left;
  logic [ADDR_W-1:0]      img_base;
  logic [ADDR_W-1:0]      word_addr;
  logic [WORD_W-9:0]      word_hi;
`ifdef CFS_WAIT_VALID_EN
  logic                   valid_seen;
`endif

  logic          byte_last, row_end, frame_last, last_pass, gap_exit;
  logic [BW-1:0] nxt_b, hi_idx;
  logic [WW-1:0] nxt_w;
  logic [RW-1:0] nxt_row;
  logic          nxt_row_end, nxt_frame_last;

  // Position of the pixel that the registered strobes will describe next cycle.
  always_comb begin
    byte_last      = (b_cnt == BW'(BYTES - 1));
    row_end        = byte_last && (w_cnt == WW'(WORDS_PER_ROW - 1));
    frame_last     = row_end && (row_cnt == RW'(ROWS - 1));
    nxt_b          = byte_last ? '0 : b_cnt + 1'b1;
    nxt_w          = row_end ? '0 : (byte_last ? w_cnt + 1'b1 : w_cnt);
    nxt_row        = row_end ? row_cnt + 1'b1 : row_cnt;
    nxt_row_end    = (nxt_b == BW'(BYTES - 1)) && (nxt_w == WW'(WORDS_PER_ROW - 1));
    nxt_frame_last = nxt_row_end && (nxt_row == RW'(ROWS - 1));
    last_pass      = (pass == PW'(PASSES - 1));
    hi_idx         = b_cnt - 1'b1;
`ifdef CFS_WAIT_VALID_EN
    gap_exit       = (gap_cnt == GW'(GAP_CYCLES - 1)) && (valid_seen || valid);
`else
    gap_exit       = (gap_cnt == GW'(GAP_CYCLES - 1));
`endif
  end

  // Byte 0 comes straight from the read port; bytes 1..7 from the captured upper word.
  assign ima = !ena_in ? '0 :
               (b_cnt == '0) ? mem_rdata[7:0] : word_hi[hi_idx*8 +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      b_cnt              <= '0;
      w_cnt              <= '0;
      row_cnt            <= '0;
      pass               <= '0;
      gap_cnt            <= '0;
      img_left           <= '0;
      img_base           <= '0;
      word_addr          <= '0;
      word_hi            <= '0;
      mem_rd_en          <= 1'b0;
      mem_addr           <= '0;
      ena_in             <= 1'b0;
      frame_start_in     <= 1'b0;
      frame_start_dim_in <= 1'b0;
      line_start_in      <= 1'b0;
      frame_end_in       <= 1'b0;
      frame_end_dim_in   <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
`ifdef CFS_WAIT_VALID_EN
      valid_seen         <= 1'b0;
`endif
    end else begin
      done               <= 1'b0;
      mem_rd_en          <= 1'b0;
      ena_in             <= 1'b0;
      frame_start_in     <= 1'b0;
      frame_start_dim_in <= 1'b0;
      line_start_in      <= 1'b0;
      frame_end_in       <= 1'b0;
      frame_end_dim_in   <= 1'b0;
`ifdef CFS_WAIT_VALID_EN
      if (valid && (state == S_GAP || (state == S_STREAM && last_pass)))
        valid_seen <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            img_left <= num_img;
            img_base <= base_addr;
            pass     <= '0;
`ifdef CFS_WAIT_VALID_EN
            valid_seen <= 1'b0;
`endif
            if (num_img != '0) begin
              state              <= S_HDR;
              frame_start_in     <= 1'b1;
              frame_start_dim_in <= 1'b1;
              line_start_in      <= 1'b1;
              mem_rd_en          <= 1'b1;
              mem_addr           <= base_addr;
              word_addr          <= base_addr;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_HDR: begin
          state   <= S_STREAM;
          b_cnt   <= '0;
          w_cnt   <= '0;
          row_cnt <= '0;
          ena_in  <= 1'b1;
        end
        S_STREAM: begin
          if (b_cnt == '0)
            word_hi <= mem_rdata[WORD_W-1:8];
          if (frame_last) begin
            if (!last_pass) begin
              state          <= S_HDR;
              pass           <= pass + 1'b1;
              frame_start_in <= 1'b1;
              line_start_in  <= 1'b1;
              mem_rd_en      <= 1'b1;
              mem_addr       <= img_base;
              word_addr      <= img_base;
            end else begin
              state    <= S_GAP;
              gap_cnt  <= '0;
              img_base <= img_base + ADDR_W'(IMG_WORDS);
              img_left <= img_left - 1'b1;
            end
          end else begin
            b_cnt            <= nxt_b;
            w_cnt            <= nxt_w;
            row_cnt          <= nxt_row;
            ena_in           <= 1'b1;
            line_start_in    <= nxt_row_end && !nxt_frame_last;
            frame_end_in     <= nxt_frame_last;
            frame_end_dim_in <= nxt_frame_last && last_pass;
            if ((nxt_b == BW'(BYTES - 1)) && !nxt_frame_last) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= word_addr + 1'b1;
              word_addr <= word_addr + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt != GW'(GAP_CYCLES - 1))
            gap_cnt <= gap_cnt + 1'b1;
          if (gap_exit) begin
`ifdef CFS_WAIT_VALID_EN
            valid_seen <= 1'b0;
`endif
            if (img_left != '0) begin
              state              <= S_HDR;
              pass               <= '0;
              frame_start_in     <= 1'b1;
              frame_start_dim_in <= 1'b1;
              line_start_in      <= 1'b1;
              mem_rd_en          <= 1'b1;
              mem_addr           <= img_base;
              word_addr          <= img_base;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      result_cnt <= '0;
    else if (state == S_IDLE && start)
      result_cnt <= '0;
    else if (valid && (result_cnt != '1))
      result_cnt <= result_cnt + 1'b1;
  end

endmodule
